// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and width helpers for the FIFO read-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, FLUSH} arb_state_t;

  // Burst-length field width: must hold 0..max_burst.
  function automatic int len_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Stall counter width: must hold 0..timeout.
  function automatic int to_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Consumer-side and FIFO-side signals of the read arbiter, bundled.
// slave = arbiter view, master = consumers/FIFO view.
interface fifo_read_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 12,
  parameter int MAX_BURST = 16
);
  localparam int LEN_W = len_w(MAX_BURST);
  localparam int ID_W  = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic                     fifo_rinc;
  logic                     fifo_rEmpty;
  logic [DATA_SIZE-1:0]     fifo_rData;
  logic [DATA_SIZE-1:0]     dout;
  logic                     dout_valid;
  logic [ID_W-1:0]          dout_id;
  logic                     dout_last;
  logic [NUM_REQ-1:0]       done;
  logic                     aborted;
  logic                     busy;

  modport slave (
    input  req, req_len, fifo_rEmpty, fifo_rData,
    output grant, fifo_rinc, dout, dout_valid, dout_id, dout_last, done, aborted, busy
  );

  modport master (
    output req, req_len, fifo_rEmpty, fifo_rData,
    input  grant, fifo_rinc, dout, dout_valid, dout_id, dout_last, done, aborted, busy
  );

endinterface

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  int   j;
  logic found;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ (NUM_REQ need not be a power of two).
  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        winner = ID_W'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares the async FIFO read port among NUM_REQ consumers: round-robin grant,
// burst of pops, tagged data return, completion / timeout-abort pulse.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 12,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 rclk,
  input  logic                 wrst,
  fifo_read_arbiter_if.slave   bus
);

  localparam int LEN_W = len_w(MAX_BURST);
  localparam int ID_W  = id_w(NUM_REQ);
  localparam int TO_W  = to_w(TIMEOUT);

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, id, winner;
  logic                 any_req;
  logic [LEN_W-1:0]     remaining, win_len, clamp_len;
  logic [TO_W-1:0]      idle_cnt;
  logic                 abort_flag;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 rinc, acc, last_pop, stall_tmo;
  logic [NUM_REQ-1:0]   done_v;
  logic                 aborted_v;
  logic                 dv_q, last_q;
  logic [ID_W-1:0]      did_q;
  logic [DATA_SIZE-1:0] hold_q;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Out-of-range lengths (0 or above MAX_BURST) become a full MAX_BURST burst.
  assign win_len   = bus.req_len[winner*LEN_W +: LEN_W];
  assign clamp_len = (win_len == '0 || win_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : win_len;

  // Next state and combinational outputs; pop request comes straight off registers.
  always_comb begin
    state_nxt = state;
    done_v    = '0;
    aborted_v = 1'b0;
    rinc      = (state == READ) && (remaining != '0);
    acc       = rinc && !bus.fifo_rEmpty;
    last_pop  = acc && (remaining == LEN_W'(1));
    stall_tmo = !acc && (idle_cnt == TO_W'(TIMEOUT - 1));
    case (state)
      IDLE:    if (any_req) state_nxt = READ;
      READ:    if (last_pop || stall_tmo) state_nxt = FLUSH;
      FLUSH: begin
        state_nxt  = IDLE;
        done_v[id] = 1'b1;
        aborted_v  = abort_flag;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant capture, burst counters and round-robin pointer.
  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      grant_q    <= '0;
      rr_ptr     <= '0;
      id         <= '0;
      remaining  <= '0;
      idle_cnt   <= '0;
      abort_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_q    <= NUM_REQ'(1) << winner;
          id         <= winner;
          remaining  <= clamp_len;
          idle_cnt   <= '0;
          abort_flag <= 1'b0;
          rr_ptr     <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
        READ: begin
          if (acc) begin
            remaining <= remaining - LEN_W'(1);
            idle_cnt  <= '0;
          end else begin
            idle_cnt  <= idle_cnt + TO_W'(1);
          end
          if (stall_tmo) abort_flag <= 1'b1;
        end
        FLUSH: grant_q <= '0;
        default: grant_q <= '0;
      endcase
    end
  end

  // Data return: the FIFO presents the word one cycle after the pop, so only
  // the valid/tag/last qualifiers are delayed; the word itself passes through
  // and is captured to hold dout steady between valid cycles.
  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      dv_q   <= 1'b0;
      last_q <= 1'b0;
      did_q  <= '0;
      hold_q <= '0;
    end else begin
      dv_q   <= acc;
      last_q <= last_pop;
      if (acc)  did_q  <= id;
      if (dv_q) hold_q <= bus.fifo_rData;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.fifo_rinc  = rinc;
  assign bus.dout       = dv_q ? bus.fifo_rData : hold_q;
  assign bus.dout_valid = dv_q;
  assign bus.dout_id    = did_q;
  assign bus.dout_last  = last_q;
  assign bus.done       = done_v;
  assign bus.aborted    = aborted_v;
  assign bus.busy       = (state != IDLE);

endmodule
